// File: rtl/conv_stream_pkg.sv
// rtl/conv_stream_pkg.sv - shared types and constants for the conv input streamer
// Purpose: FSM state type and buffering constants used by conv_input_streamer
//          and stream_skid_fifo.
package conv_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } streamer_state_t;

  localparam int STREAM_FIFO_DEPTH = 2;
  localparam int MEM_READ_LATENCY  = 1;

endpackage

// File: rtl/adder.sv
// rtl/adder.sv - shared modular adder used by datapath counters
// Purpose: WIDTH-bit add, result wraps modulo 2^WIDTH.
// Ports:
//   i_a, i_b  in   operands
//   o_sum     out  i_a + i_b (carry discarded)
module adder #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum
);

  assign o_sum = i_a + i_b;

endmodule

// File: rtl/stream_skid_fifo.sv
// rtl/stream_skid_fifo.sv - 2-entry output FIFO for the conv input streamer
// Purpose: holds words returned from memory until the consumer accepts them.
//          Head word is a register, so o_data never depends on i_pop.
// Ports:
//   clk, i_arst_n  in   clock, asynchronous active-low reset
//   i_push/i_data  in   write a word (caller guarantees not full)
//   i_pop          in   drop head word (caller guarantees not empty)
//   o_data         out  head word
//   o_full/o_empty out  occupancy flags
//   o_count        out  occupancy 0..2
module stream_skid_fifo
  import conv_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  i_arst_n,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [1:0]            o_count
);

  logic [DATA_WIDTH-1:0] r_mem [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;
  logic [1:0]            w_delta;
  logic [1:0]            w_count_nxt;

  // +1 on push only, -1 (all ones) on pop only, unchanged otherwise
  always_comb begin
    w_delta = 2'd0;
    if (i_push && !i_pop) begin
      w_delta = 2'd1;
    end else if (i_pop && !i_push) begin
      w_delta = 2'b11;
    end
  end

  adder #(.WIDTH(2)) u_count_add (
    .i_a   (r_count),
    .i_b   (w_delta),
    .o_sum (w_count_nxt)
  );

  always_ff @(posedge clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= w_count_nxt;
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == 2'd0);
  assign o_full  = (r_count == 2'(STREAM_FIFO_DEPTH));
  assign o_count = r_count;

endmodule

// File: rtl/conv_input_streamer.sv
// rtl/conv_input_streamer.sv - memory-to-stream burst reader for one accelerator input channel
// Purpose: reads length words from base_addr (repeated repeat_count+1 times) out of a
//          1-cycle-latency memory and streams them on a valid/ready channel.
// Optional: CONV_STREAMER_STALL_CNT_EN enables the stall_cycles back-pressure counter;
//           without it stall_cycles is tied to 0.
// Ports:
//   clk, arst_n_in                     clock, asynchronous active-low reset
//   start, base_addr, length,
//   repeat_count                       command (sampled in IDLE only)
//   busy, done                         status; done pulses once per command
//   mem_addr, mem_re, mem_rdata        synchronous-read memory port
//   out_data, out_valid, out_ready     output stream
//   stall_cycles                       cycles spent stalled with valid data
module conv_input_streamer
  import conv_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 16,
  parameter int REP_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  arst_n_in,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic [REP_WIDTH-1:0]  repeat_count,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           stall_cycles
);

  streamer_state_t       r_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_burst_left;
  logic [REP_WIDTH-1:0]  r_reps_left;
  logic                  r_rd_pend;
  logic                  r_done;

  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [1:0]            w_fifo_count;
  logic                  w_pop;
  logic                  w_can_issue;
  logic                  w_issue;
  logic                  w_last_in_burst;
  logic                  w_final_hs;
  logic                  w_start_ok;
  logic                  w_start_zero;
  logic [ADDR_WIDTH-1:0] w_addr_inc;
  logic [LEN_WIDTH-1:0]  w_burst_dec;
  logic [REP_WIDTH-1:0]  w_reps_dec;

  stream_skid_fifo #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
    .clk      (clk),
    .i_arst_n (arst_n_in),
    .i_push   (r_rd_pend),
    .i_data   (mem_rdata),
    .i_pop    (w_pop),
    .o_data   (out_data),
    .o_full   (w_fifo_full),
    .o_empty  (w_fifo_empty),
    .o_count  (w_fifo_count)
  );

  assign out_valid = !w_fifo_empty;
  assign w_pop     = out_valid && out_ready;

  // Credit check: occupancy + returning read - word leaving this cycle must
  // leave room for the read issued now. Counting the departing word is what
  // lets a full pipeline sustain one word per cycle.
  always_comb begin
    w_can_issue = 1'b1;
    if (w_fifo_full) begin
      w_can_issue = !r_rd_pend && w_pop;
    end else if (w_fifo_count == 2'd1) begin
      w_can_issue = !r_rd_pend || w_pop;
    end
  end

  assign w_issue         = (r_state == STREAM) && w_can_issue;
  assign mem_re          = w_issue;
  assign mem_addr        = r_addr;
  assign busy            = (r_state != IDLE);
  assign done            = r_done;
  assign w_last_in_burst = (r_burst_left == {{(LEN_WIDTH-1){1'b0}}, 1'b1});
  assign w_start_ok      = (r_state == IDLE) && start && (length != '0);
  assign w_start_zero    = (r_state == IDLE) && start && (length == '0);
  // Last word leaves: nothing left in memory pipe, only the head word remains
  assign w_final_hs      = (r_state == DRAIN) && w_pop && !r_rd_pend && (w_fifo_count == 2'd1);

  adder #(.WIDTH(ADDR_WIDTH)) u_addr_inc (
    .i_a   (r_addr),
    .i_b   ({{(ADDR_WIDTH-1){1'b0}}, 1'b1}),
    .o_sum (w_addr_inc)
  );

  adder #(.WIDTH(LEN_WIDTH)) u_burst_dec (
    .i_a   (r_burst_left),
    .i_b   ({LEN_WIDTH{1'b1}}),
    .o_sum (w_burst_dec)
  );

  adder #(.WIDTH(REP_WIDTH)) u_reps_dec (
    .i_a   (r_reps_left),
    .i_b   ({REP_WIDTH{1'b1}}),
    .o_sum (w_reps_dec)
  );

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      r_state      <= IDLE;
      r_base       <= '0;
      r_addr       <= '0;
      r_len        <= '0;
      r_burst_left <= '0;
      r_reps_left  <= '0;
      r_rd_pend    <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_rd_pend <= w_issue;
      r_done    <= w_final_hs || w_start_zero;
      case (r_state)
        IDLE: begin
          if (w_start_ok) begin
            r_state      <= STREAM;
            r_base       <= base_addr;
            r_addr       <= base_addr;
            r_len        <= length;
            r_burst_left <= length;
            r_reps_left  <= repeat_count;
          end
        end
        STREAM: begin
          if (w_issue) begin
            if (w_last_in_burst) begin
              if (r_reps_left == '0) begin
                r_state <= DRAIN;
              end else begin
                // wrap to the start of the burst with no idle cycle
                r_reps_left  <= w_reps_dec;
                r_burst_left <= r_len;
                r_addr       <= r_base;
              end
            end else begin
              r_burst_left <= w_burst_dec;
              r_addr       <= w_addr_inc;
            end
          end
        end
        DRAIN: begin
          if (w_final_hs) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef CONV_STREAMER_STALL_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] w_stall_inc;

  adder #(.WIDTH(32)) u_stall_inc (
    .i_a   (r_stall_cycles),
    .i_b   (32'd1),
    .o_sum (w_stall_inc)
  );

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      r_stall_cycles <= '0;
    end else if ((r_state == IDLE) && start) begin
      r_stall_cycles <= '0;
    end else if (busy && out_valid && !out_ready && (r_stall_cycles != '1)) begin
      r_stall_cycles <= w_stall_inc;
    end
  end

  assign stall_cycles = r_stall_cycles;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule
